crc_ram_scanner: RTL and testbench

Read-only scan engine on the second port of the 256x8 dual-port CRC RAM. On a start pulse it streams a byte range (base address, length, wrapping modulo 256) out of the RAM at one byte per clock and computes CRC-16/CCITT-FALSE over it, MSB first. It reports the result with a done pulse, for the coil-driver control logic to check configuration and table integrity. Port 1 of the RAM stays with the host, and the scanner never writes.

---
 rtl/crc_ram_scanner.sv | 158 +++++++++++++++
 tb/tb_crc_ram_scanner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_ram_scanner.sv
// Read-only scan engine on port 2 of the 256x8 CRC RAM: streams a byte range and computes CRC-16/CCITT-FALSE.
// Optional stored-CRC compare (crc_ok, two extra reads) is enabled by defining CRC_RAM_SCAN_CHECK_EN.
module crc_ram_scanner (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  base_addr,
  input  logic [8:0]  length,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  output logic [15:0] crc,
`ifdef CRC_RAM_SCAN_CHECK_EN
  output logic        crc_ok,
`endif
  output logic [7:0]  ram_address,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic [7:0]  ram_writedata,
  output logic        ram_clken,
  input  logic [7:0]  ram_readdata
);

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;
`ifdef CRC_RAM_SCAN_CHECK_EN
  localparam logic [8:0]  EXTRA    = 9'd2;
`else
  localparam logic [8:0]  EXTRA    = 9'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  // Eight unrolled MSB-first shift steps fold one byte per clock.
  function automatic logic [15:0] crc_fold(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  state_t      r_state;
  logic [8:0]  r_len;
  logic [8:0]  r_cnt;
  logic [8:0]  r_idx;
  logic [8:0]  r_fidx;
  logic        r_valid;
  logic [15:0] r_crc_reg;
`ifdef CRC_RAM_SCAN_CHECK_EN
  logic [7:0]  r_hi;
`endif

  logic        w_fold_data;
  logic [15:0] w_crc_next;
  logic [8:0]  w_total;

  assign ram_write     = 1'b0;
  assign ram_writedata = 8'h00;
  assign ram_clken     = 1'b1;

  // Read data lines up with chipselect delayed by one cycle; only indices below length are data bytes.
  assign w_fold_data = r_valid && (r_fidx < r_len);
  assign w_crc_next  = w_fold_data ? crc_fold(r_crc_reg, ram_readdata) : r_crc_reg;
  assign w_total     = length + EXTRA;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_fidx         <= '0;
      r_valid        <= 1'b0;
      r_crc_reg      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      len_err        <= 1'b0;
      crc            <= '0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
`ifdef CRC_RAM_SCAN_CHECK_EN
      r_hi           <= '0;
      crc_ok         <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      len_err   <= 1'b0;
      r_valid   <= ram_chipselect;
      r_crc_reg <= w_crc_next;
      if (r_valid) r_fidx <= r_fidx + 9'd1;
`ifdef CRC_RAM_SCAN_CHECK_EN
      if (r_valid && (r_fidx == r_len)) r_hi <= ram_readdata;
`endif

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (length > 9'd256) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              len_err <= 1'b1;
`ifdef CRC_RAM_SCAN_CHECK_EN
              crc_ok  <= 1'b0;
`endif
            end else begin
              r_len       <= length;
              r_cnt       <= w_total;
              r_idx       <= '0;
              r_fidx      <= '0;
              r_crc_reg   <= CRC_INIT;
              ram_address <= base_addr;
              if (w_total == 9'd0) begin
                r_state <= S_DONE;
                done    <= 1'b1;
                crc     <= CRC_INIT;
              end else begin
                r_state        <= S_ISSUE;
                busy           <= 1'b1;
                ram_chipselect <= 1'b1;
              end
            end
          end
        end

        S_ISSUE: begin
          if (r_idx == r_cnt - 9'd1) begin
            r_state        <= S_DRAIN;
            ram_chipselect <= 1'b0;
          end else begin
            r_idx       <= r_idx + 9'd1;
            ram_address <= ram_address + 8'd1;
          end
        end

        S_DRAIN: begin
          // The last byte is on ram_readdata now, so the result is published on the way into DONE.
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          crc     <= w_crc_next;
`ifdef CRC_RAM_SCAN_CHECK_EN
          crc_ok  <= (w_crc_next == {r_hi, ram_readdata});
`endif
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_ram_scanner.sv
// Self-checking bench for crc_ram_scanner: a directed vector table plus hand-written reset/overlap/compare sequences.
// Works in both builds; the CRC_RAM_SCAN_CHECK_EN paths are exercised when that macro is defined.
module tb_crc_ram_scanner;

`ifdef CRC_RAM_SCAN_CHECK_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        busy;
  logic        done;
  logic        len_err;
  logic [15:0] crc;
`ifdef CRC_RAM_SCAN_CHECK_EN
  logic        crc_ok;
`endif
  logic [7:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [7:0]  ram_writedata;
  logic        ram_clken;
  logic [7:0]  ram_readdata;

  logic [7:0]  mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  crc_ram_scanner dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .len_err        (len_err),
    .crc            (crc),
`ifdef CRC_RAM_SCAN_CHECK_EN
    .crc_ok         (crc_ok),
`endif
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM port 2 with one cycle of latency.
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect && !ram_write) ram_readdata <= mem[ram_address];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-serial reference over the bench's RAM image (wraps modulo 256).
  function automatic logic [15:0] ref_crc(input logic [7:0] b, input int n);
    logic [15:0] c;
    logic [7:0]  a;
    logic [7:0]  d;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      d = mem[a];
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ d[j];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  // Called at a negedge; start is seen by the next posedge (cycle T). k counts cycles after T.
  task automatic run_scan(input logic [7:0] b, input logic [8:0] l,
                          output int done_cyc, output int nreads, output int addr_err,
                          output logic lerr, output logic [15:0] c, output logic ok);
    logic [7:0] ea;
    done_cyc = -1; nreads = 0; addr_err = 0; lerr = 1'bx; c = 'x; ok = 1'b0;
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (ram_chipselect) begin
        ea = b + 8'(nreads);
        if (ram_address !== ea || k != nreads + 1) addr_err++;
        nreads++;
      end
      if (done) begin
        done_cyc = k;
        lerr     = len_err;
        c        = crc;
`ifdef CRC_RAM_SCAN_CHECK_EN
        ok       = crc_ok;
`endif
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    logic [15:0] exp_crc;
    logic        exp_le;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          dc, nr, ae, cnt_done, cnt_cs, exp_reads, exp_done;
    logic        le, ok;
    logic [15:0] c;
    string       nm;
    logic [7:0]  digits [9];

    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 9; i++) begin
      mem[8'h10 + i]        = digits[i];
      mem[8'(8'hFC + i)]    = digits[i];
    end
    mem[8'h19] = 8'h29; mem[8'h1A] = 8'hB1;
    mem[8'h40] = 8'h00; mem[8'h41] = 8'hFF; mem[8'h42] = 8'h00;

    vecs[0] = '{8'h10, 9'd9,   16'h29B1, 1'b0};
    vecs[1] = '{8'h33, 9'd0,   16'hFFFF, 1'b0};
    vecs[2] = '{8'hFC, 9'd9,   16'h29B1, 1'b0};
    vecs[3] = '{8'h40, 9'd1,   16'hE1F0, 1'b0};
    vecs[4] = '{8'h41, 9'd1,   16'hFF00, 1'b0};
    vecs[5] = '{8'h41, 9'd2,   16'h1EF0, 1'b0};
    vecs[6] = '{8'h55, 9'd257, 16'h1EF0, 1'b1};
    vecs[7] = '{8'h80, 9'd256, ref_crc(8'h80, 256), 1'b0};
    vecs[8] = '{8'h00, 9'd511, vecs[7].exp_crc, 1'b1};

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset len_err", len_err, 0);
    check("reset crc", crc, 16'h0000);
    check("reset chipselect", ram_chipselect, 0);
    check("reset address", ram_address, 8'h00);
    check("tie write", ram_write, 0);
    check("tie clken", ram_clken, 1);
`ifdef CRC_RAM_SCAN_CHECK_EN
    check("reset crc_ok", crc_ok, 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_scan(vecs[i].base, vecs[i].len, dc, nr, ae, le, c, ok);
      exp_reads = vecs[i].exp_le ? 0 : int'(vecs[i].len) + EXTRA;
      exp_done  = (exp_reads == 0) ? 1 : exp_reads + 2;
      nm = $sformatf("row%0d", i);
      check({nm, " done_cycle"}, dc, exp_done);
      check({nm, " reads"}, nr, exp_reads);
      check({nm, " addr_errors"}, ae, 0);
      check({nm, " len_err"}, le, vecs[i].exp_le);
      check({nm, " crc"}, c, vecs[i].exp_crc);
    end

    // A second start while busy must be ignored: one done, nine data reads only.
    cnt_done = 0; cnt_cs = 0; c = 'x;
    start = 1'b1; base_addr = 8'h10; length = 9'd9;
    @(negedge clk);
    start = 1'b0;
    check("overlap busy", busy, 1);
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin start = 1'b1; base_addr = 8'h40; length = 9'd1; end
      if (k == 4) start = 1'b0;
      if (ram_chipselect) cnt_cs++;
      if (done) begin cnt_done++; c = crc; end
      @(negedge clk);
    end
    check("overlap done_count", cnt_done, 1);
    check("overlap reads", cnt_cs, 9 + EXTRA);
    check("overlap crc", c, 16'h29B1);

    // Reset in the middle of a scan aborts without a done pulse.
    start = 1'b1; base_addr = 8'h10; length = 9'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort chipselect", ram_chipselect, 0);
    check("abort crc", crc, 16'h0000);
    check("abort address", ram_address, 8'h00);
    cnt_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("abort done_count", cnt_done, 0);
    run_scan(8'h10, 9'd9, dc, nr, ae, le, c, ok);
    check("restart done_cycle", dc, 11 + EXTRA);
    check("restart crc", c, 16'h29B1);
    check("restart done_pulse_low", done, 0);

`ifdef CRC_RAM_SCAN_CHECK_EN
    run_scan(8'h10, 9'd9, dc, nr, ae, le, c, ok);
    check("cmp good done_cycle", dc, 13);
    check("cmp good crc_ok", ok, 1);
    check("cmp good held", crc_ok, 1);
    run_scan(8'h10, 9'd300, dc, nr, ae, le, c, ok);
    check("cmp len_err crc_ok", ok, 0);
    run_scan(8'h33, 9'd0, dc, nr, ae, le, c, ok);
    check("cmp zero-len reads", nr, 2);
    check("cmp zero-len done_cycle", dc, 4);
    mem[8'h1A] = 8'hB0;
    run_scan(8'h10, 9'd9, dc, nr, ae, le, c, ok);
    check("cmp bad crc", c, 16'h29B1);
    check("cmp bad crc_ok", ok, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
